// File: rtl/msg_header_mux_pkg.sv
// Shared message-framing definitions for the transmit and receive paths:
// sync bytes, header layout, state encoding and the length clamp.
package msg_header_mux_pkg;

  localparam logic [7:0] SyncByte1       = 8'h34;
  localparam logic [7:0] SyncByte2       = 8'h12;
  localparam int         HeaderByteCount = 8;

  // Byte offsets inside the 8-byte header (low byte of each field first)
  localparam logic [2:0] SyncLow       = 3'd0;
  localparam logic [2:0] SyncHigh      = 3'd1;
  localparam logic [2:0] ByteCountLow  = 3'd2;
  localparam logic [2:0] ByteCountHigh = 3'd3;
  localparam logic [2:0] MsgIdLow      = 3'd4;
  localparam logic [2:0] MsgIdHigh     = 3'd5;
  localparam logic [2:0] SeqLow        = 3'd6;
  localparam logic [2:0] SeqHigh       = 3'd7;

  // State encoding
  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StLoadHeader = 3'd1;
  localparam logic [2:0] StSendHeader = 3'd2;
  localparam logic [2:0] StClearAddr  = 3'd3;
  localparam logic [2:0] StWaitRam    = 3'd4;
  localparam logic [2:0] StSendData   = 3'd5;
  localparam logic [2:0] StMsgSent    = 3'd6;

  typedef enum logic [2:0] {
    IDLE        = StIdle,
    LOAD_HEADER = StLoadHeader,
    SEND_HEADER = StSendHeader,
    CLEAR_ADDR  = StClearAddr,
    WAIT_RAM    = StWaitRam,
    SEND_DATA   = StSendData,
    MSG_SENT    = StMsgSent
  } state_t;

  // Effective message length: never shorter than a header, never above the maximum
  function automatic logic [15:0] clamp_len(input logic [15:0] byte_count,
                                            input logic [15:0] max_count);
    logic [15:0] len;
    if (byte_count < 16'(HeaderByteCount)) begin
      len = 16'(HeaderByteCount);
    end else if (byte_count > max_count) begin
      len = max_count;
    end else begin
      len = byte_count;
    end
    return len;
  endfunction

endpackage

// File: rtl/msg_header_mux_if.sv
// Controller / data RAM / serializer signal bundle around msg_header_mux.
// slave is the mux's view; master is the surrounding system's view.
interface msg_header_mux_if;

  logic        Send;
  logic [15:0] MessageID;
  logic [15:0] ByteCount;
  logic        Busy;
  logic        MessageSent;
  logic [15:0] SequenceNumber;
  logic        ClearDataByteAddr;
  logic        NextDataByte;
  logic [7:0]  DataByte;
  logic [7:0]  TxByte;
  logic        TxValid;
  logic        TxReady;

  modport master (
    output Send, MessageID, ByteCount, DataByte, TxReady,
    input  Busy, MessageSent, SequenceNumber, ClearDataByteAddr, NextDataByte,
           TxByte, TxValid
  );

  modport slave (
    input  Send, MessageID, ByteCount, DataByte, TxReady,
    output Busy, MessageSent, SequenceNumber, ClearDataByteAddr, NextDataByte,
           TxByte, TxValid
  );

endinterface

// File: rtl/msg_header_mux_rom.sv
// Header byte selector: picks one of the eight header bytes by index.
module msg_header_mux_rom
  import msg_header_mux_pkg::*;
(
  input  logic [2:0]  index,
  input  logic [15:0] len,
  input  logic [15:0] msg_id,
  input  logic [15:0] seq,
  output logic [7:0]  hdr_byte
);

  // 8-to-1 byte select, low byte of each field first
  always_comb begin
    hdr_byte = 8'h00;
    case (index)
      SyncLow:       hdr_byte = SyncByte1;
      SyncHigh:      hdr_byte = SyncByte2;
      ByteCountLow:  hdr_byte = len[7:0];
      ByteCountHigh: hdr_byte = len[15:8];
      MsgIdLow:      hdr_byte = msg_id[7:0];
      MsgIdHigh:     hdr_byte = msg_id[15:8];
      SeqLow:        hdr_byte = seq[7:0];
      SeqHigh:       hdr_byte = seq[15:8];
      default:       hdr_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/msg_header_mux.sv
// Transmit message serializer: emits an 8-byte header followed by payload
// bytes fetched from the transmit data RAM, one byte per serializer handshake.
module msg_header_mux
  import msg_header_mux_pkg::*;
#(
  parameter logic [15:0] MaxByteCount = 16'd264,
  parameter int          RamLatency   = 1
) (
  input logic             Clock,
  input logic             Clear,
  msg_header_mux_if.slave bus
);

  localparam logic [1:0]  RamLatW = 2'(RamLatency);
  localparam logic [15:0] HdrLen  = 16'(HeaderByteCount);

  state_t      state_r, state_s;
  logic [15:0] cnt_r, len_r, msg_id_r, seq_cap_r, seq_r;
  logic [1:0]  wait_r;
  logic [7:0]  tx_byte_r;
  logic        tx_valid_r, busy_r, msg_sent_r, clr_addr_r;
  logic [7:0]  hdr_byte_s;
  logic [15:0] cnt_inc_s;
  logic        wait_done_s, next_byte_s;

  assign cnt_inc_s   = cnt_r + 16'd1;
  // WaitRam lasts RamLatency+1 cycles so DataByte has settled at the capture edge
  assign wait_done_s = (wait_r == RamLatW);

  msg_header_mux_rom u_rom (
    .index    (cnt_r[2:0]),
    .len      (len_r),
    .msg_id   (msg_id_r),
    .seq      (seq_cap_r),
    .hdr_byte (hdr_byte_s)
  );

  // State register
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; NextDataByte must coincide with the accepted data byte
  always_comb begin
    state_s     = state_r;
    next_byte_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.Send) state_s = LOAD_HEADER;
        else          state_s = IDLE;
      end
      LOAD_HEADER: state_s = SEND_HEADER;
      SEND_HEADER: begin
        if (bus.TxReady) begin
          if (cnt_inc_s < HdrLen)   state_s = LOAD_HEADER;
          else if (len_r == HdrLen) state_s = MSG_SENT;
          else                      state_s = CLEAR_ADDR;
        end else begin
          state_s = SEND_HEADER;
        end
      end
      CLEAR_ADDR: state_s = WAIT_RAM;
      WAIT_RAM: begin
        if (wait_done_s) state_s = SEND_DATA;
        else             state_s = WAIT_RAM;
      end
      SEND_DATA: begin
        if (bus.TxReady) begin
          if (cnt_inc_s == len_r) begin
            state_s = MSG_SENT;
          end else begin
            next_byte_s = 1'b1;
            state_s     = WAIT_RAM;
          end
        end else begin
          state_s = SEND_DATA;
        end
      end
      MSG_SENT: state_s = IDLE;
      default:  state_s = IDLE;
    endcase
  end

  // Registered status outputs, decoded from the state being entered
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      msg_sent_r <= 1'b0;
      clr_addr_r <= 1'b0;
    end else begin
      tx_valid_r <= (state_s == SEND_HEADER) || (state_s == SEND_DATA);
      busy_r     <= (state_s != IDLE);
      msg_sent_r <= (state_s == MSG_SENT);
      clr_addr_r <= (state_s == CLEAR_ADDR);
    end
  end

  // Message capture on an accepted Send, byte counter on every transfer
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      cnt_r     <= 16'd0;
      len_r     <= 16'd0;
      msg_id_r  <= 16'd0;
      seq_cap_r <= 16'd0;
    end else if ((state_r == IDLE) && bus.Send) begin
      cnt_r     <= 16'd0;
      len_r     <= clamp_len(bus.ByteCount, MaxByteCount);
      msg_id_r  <= bus.MessageID;
      seq_cap_r <= seq_r;
    end else if (((state_r == SEND_HEADER) || (state_r == SEND_DATA)) && bus.TxReady) begin
      cnt_r <= cnt_inc_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // RAM latency counter, restarted on every entry into WaitRam
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      wait_r <= 2'd0;
    end else if ((state_r == WAIT_RAM) && !wait_done_s) begin
      wait_r <= wait_r + 2'd1;
    end else begin
      wait_r <= 2'd0;
    end
  end

  // Output byte register: only loaded when entering a Send state, so it is stable while offered
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      tx_byte_r <= 8'h00;
    end else if (state_r == LOAD_HEADER) begin
      tx_byte_r <= hdr_byte_s;
    end else if ((state_r == WAIT_RAM) && wait_done_s) begin
      tx_byte_r <= bus.DataByte;
    end else begin
      tx_byte_r <= tx_byte_r;
    end
  end

  // Sequence number advances only for completed messages (captured value + 1)
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      seq_r <= 16'd0;
    end else if (state_r == MSG_SENT) begin
      seq_r <= seq_cap_r + 16'd1;
    end else begin
      seq_r <= seq_r;
    end
  end

  assign bus.TxByte            = tx_byte_r;
  assign bus.TxValid           = tx_valid_r;
  assign bus.Busy              = busy_r;
  assign bus.MessageSent       = msg_sent_r;
  assign bus.ClearDataByteAddr = clr_addr_r;
  assign bus.NextDataByte      = next_byte_s;
  assign bus.SequenceNumber    = seq_r;

endmodule

// File: tb/tb_msg_header_mux.sv
// Directed bench for msg_header_mux: header-only, payload, backpressure,
// clamping, ignored Send, sequence wrap and asynchronous Clear.
module tb_msg_header_mux;

  logic Clock = 1'b0;
  logic Clear;
  always #5 Clock = ~Clock;

  msg_header_mux_if bus ();

  msg_header_mux #(.MaxByteCount(16'd264), .RamLatency(1)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Data RAM model: read address register plus one-cycle registered read
  logic [7:0] ram [256];
  logic [7:0] ram_addr = 8'h00;
  logic [7:0] ram_q    = 8'h00;
  always @(posedge Clock) begin
    if (bus.ClearDataByteAddr)  ram_addr <= 8'h00;
    else if (bus.NextDataByte)  ram_addr <= ram_addr + 8'h01;
    ram_q <= ram[ram_addr];
  end
  assign bus.DataByte = ram_q;

  // TxReady driver: held high, or following a fixed stall pattern
  logic stall_en = 1'b0;
  initial begin
    logic [15:0] pat;
    int k;
    pat = 16'b1011_0011_1000_1101;
    k = 0;
    bus.TxReady = 1'b1;
    forever begin
      @(posedge Clock);
      #1;
      if (stall_en) bus.TxReady = pat[k % 16];
      else          bus.TxReady = 1'b1;
      k++;
    end
  end

  // Monitor: transfers, pulse counts and stall stability, sampled at negedge
  logic [7:0] rx_q [$];
  int clr_cnt = 0, nxt_cnt = 0, sent_cnt = 0, stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;
  always @(negedge Clock) begin
    if (bus.TxValid && bus.TxReady) rx_q.push_back(bus.TxByte);
    if (bus.ClearDataByteAddr) clr_cnt <= clr_cnt + 1;
    if (bus.NextDataByte)      nxt_cnt <= nxt_cnt + 1;
    if (bus.MessageSent)       sent_cnt <= sent_cnt + 1;
    if (prev_stall && (!bus.TxValid || (bus.TxByte !== prev_byte))) stab_err <= stab_err + 1;
    prev_stall <= bus.TxValid && !bus.TxReady;
    prev_byte  <= bus.TxByte;
  end

  task automatic start_send(input logic [15:0] id, input logic [15:0] bc);
    @(posedge Clock); #1;
    bus.Send = 1'b1; bus.MessageID = id; bus.ByteCount = bc;
    @(posedge Clock); #1;
    bus.Send = 1'b0;
  endtask

  task automatic wait_sent(input int start_sent, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clock);
      if (sent_cnt > start_sent) begin ok = 1'b1; break; end
    end
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    bus.Send = 1'b0; bus.MessageID = 16'h0000; bus.ByteCount = 16'h0000;
    repeat (3) @(negedge Clock);
    checks++;
    if ({bus.TxValid, bus.Busy, bus.MessageSent, bus.ClearDataByteAddr, bus.NextDataByte} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got %b exp 00000", {bus.TxValid, bus.Busy, bus.MessageSent, bus.ClearDataByteAddr, bus.NextDataByte});
    end
    checks++;
    if (bus.TxByte !== 8'h00 || bus.SequenceNumber !== 16'h0000) begin
      failures++; $display("FAIL reset_values got byte=%02h seq=%04h exp 00/0000", bus.TxByte, bus.SequenceNumber);
    end
    Clear = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if (bus.Busy !== 1'b0 || bus.TxValid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got busy=%b valid=%b exp 0/0", bus.Busy, bus.TxValid);
    end
  endtask

  task automatic test_header_only();
    logic [7:0] exp [8];
    int base, c0, n0, s0;
    bit ok;
    exp = '{8'h34, 8'h12, 8'h08, 8'h00, 8'h02, 8'h01, 8'h00, 8'h00};
    base = rx_q.size(); c0 = clr_cnt; n0 = nxt_cnt; s0 = sent_cnt;
    start_send(16'h0102, 16'd8);
    wait_sent(s0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL hdr_only_timeout got no MessageSent exp one"); end
    checks++;
    if (rx_q.size() - base != 8) begin failures++; $display("FAIL hdr_only_len got %0d exp 8", rx_q.size() - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_q[base + i] !== exp[i]) begin failures++; $display("FAIL hdr_only_byte%0d got %02h exp %02h", i, rx_q[base + i], exp[i]); end
    end
    checks++;
    if (clr_cnt - c0 != 0 || nxt_cnt - n0 != 0 || sent_cnt - s0 != 1) begin
      failures++; $display("FAIL hdr_only_pulses got clr=%0d nxt=%0d sent=%0d exp 0/0/1", clr_cnt - c0, nxt_cnt - n0, sent_cnt - s0);
    end
    checks++;
    if (bus.SequenceNumber !== 16'h0001 || bus.Busy !== 1'b0) begin
      failures++; $display("FAIL hdr_only_seq got seq=%04h busy=%b exp 0001/0", bus.SequenceNumber, bus.Busy);
    end
  endtask

  // Payload message (11 bytes) either unstalled or with TxReady stalls
  task automatic test_payload(input bit stalled, input logic [7:0] seq_lo);
    logic [7:0] exp [11];
    int base, c0, n0, s0, e0;
    bit ok;
    exp = '{8'h34, 8'h12, 8'h0B, 8'h00, 8'hEF, 8'hBE, seq_lo, 8'h00, 8'hA0, 8'hA1, 8'hA2};
    ram[0] = 8'hA0; ram[1] = 8'hA1; ram[2] = 8'hA2;
    base = rx_q.size(); c0 = clr_cnt; n0 = nxt_cnt; s0 = sent_cnt; e0 = stab_err;
    stall_en = stalled;
    start_send(16'hBEEF, 16'd11);
    wait_sent(s0, ok);
    stall_en = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL payload_timeout stalled=%0d got no MessageSent exp one", stalled); end
    checks++;
    if (rx_q.size() - base != 11) begin failures++; $display("FAIL payload_len stalled=%0d got %0d exp 11", stalled, rx_q.size() - base); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (rx_q[base + i] !== exp[i]) begin failures++; $display("FAIL payload_byte%0d stalled=%0d got %02h exp %02h", i, stalled, rx_q[base + i], exp[i]); end
    end
    checks++;
    if (clr_cnt - c0 != 1 || nxt_cnt - n0 != 2 || sent_cnt - s0 != 1) begin
      failures++; $display("FAIL payload_pulses stalled=%0d got clr=%0d nxt=%0d sent=%0d exp 1/2/1", stalled, clr_cnt - c0, nxt_cnt - n0, sent_cnt - s0);
    end
    checks++;
    if (stab_err != e0) begin failures++; $display("FAIL stall_stability got %0d violations exp 0", stab_err - e0); end
  endtask

  task automatic test_clamp();
    logic [7:0] exp_lo [8];
    logic [7:0] exp_hi [8];
    logic [7:0] d;
    int base, c0, n0, s0, bad;
    bit ok;
    // ByteCount below a header: header-only, count field 0x0008
    exp_lo = '{8'h34, 8'h12, 8'h08, 8'h00, 8'h04, 8'h04, 8'h03, 8'h00};
    base = rx_q.size(); c0 = clr_cnt; s0 = sent_cnt;
    start_send(16'h0404, 16'd3);
    wait_sent(s0, ok);
    checks++;
    if (!ok || rx_q.size() - base != 8 || clr_cnt != c0) begin
      failures++; $display("FAIL clamp_low_shape got ok=%0d len=%0d clr=%0d exp 1/8/0", ok, rx_q.size() - base, clr_cnt - c0);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_q[base + i] !== exp_lo[i]) begin failures++; $display("FAIL clamp_low_byte%0d got %02h exp %02h", i, rx_q[base + i], exp_lo[i]); end
    end
    // ByteCount 0x1000 clamps to 264: count field 0x0108, 256 data bytes
    for (int i = 0; i < 256; i++) begin d = 8'(i); ram[i] = d ^ 8'h5A; end
    exp_hi = '{8'h34, 8'h12, 8'h08, 8'h01, 8'hCD, 8'hAB, 8'h04, 8'h00};
    base = rx_q.size(); c0 = clr_cnt; n0 = nxt_cnt; s0 = sent_cnt;
    start_send(16'hABCD, 16'h1000);
    wait_sent(s0, ok);
    checks++;
    if (!ok || rx_q.size() - base != 264) begin failures++; $display("FAIL clamp_high_len got ok=%0d len=%0d exp 1/264", ok, rx_q.size() - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_q[base + i] !== exp_hi[i]) begin failures++; $display("FAIL clamp_high_byte%0d got %02h exp %02h", i, rx_q[base + i], exp_hi[i]); end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      d = 8'(i);
      if (rx_q[base + 8 + i] !== (d ^ 8'h5A)) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL clamp_high_data got %0d wrong bytes exp 0", bad); end
    checks++;
    if (clr_cnt - c0 != 1 || nxt_cnt - n0 != 255) begin
      failures++; $display("FAIL clamp_high_pulses got clr=%0d nxt=%0d exp 1/255", clr_cnt - c0, nxt_cnt - n0);
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] exp [9];
    int base, s0;
    bit ok;
    exp = '{8'h34, 8'h12, 8'h09, 8'h00, 8'h05, 8'h05, 8'h05, 8'h00, 8'h77};
    ram[0] = 8'h77;
    base = rx_q.size(); s0 = sent_cnt;
    start_send(16'h0505, 16'd9);
    repeat (4) @(posedge Clock);
    #1;
    checks++;
    if (bus.Busy !== 1'b1) begin failures++; $display("FAIL busy_high got %b exp 1", bus.Busy); end
    bus.Send = 1'b1; bus.MessageID = 16'hDEAD; bus.ByteCount = 16'd8;
    @(posedge Clock); #1;
    bus.Send = 1'b0;
    wait_sent(s0, ok);
    repeat (30) @(negedge Clock);
    checks++;
    if (!ok || sent_cnt - s0 != 1 || rx_q.size() - base != 9) begin
      failures++; $display("FAIL busy_ignore got ok=%0d sent=%0d len=%0d exp 1/1/9", ok, sent_cnt - s0, rx_q.size() - base);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (rx_q[base + i] !== exp[i]) begin failures++; $display("FAIL busy_ignore_byte%0d got %02h exp %02h", i, rx_q[base + i], exp[i]); end
    end
    checks++;
    if (bus.SequenceNumber !== 16'h0006) begin failures++; $display("FAIL busy_seq got %04h exp 0006", bus.SequenceNumber); end
  endtask

  task automatic test_seq_wrap();
    logic [7:0] exp [8];
    int base, s0;
    bit ok;
    exp = '{8'h34, 8'h12, 8'h08, 8'h00, 8'h11, 8'h11, 8'hFF, 8'hFF};
    base = rx_q.size(); s0 = sent_cnt;
    force dut.seq_r = 16'hFFFF;
    start_send(16'h1111, 16'd8);
    release dut.seq_r;
    wait_sent(s0, ok);
    checks++;
    if (!ok || rx_q.size() - base != 8) begin failures++; $display("FAIL wrap_len got ok=%0d len=%0d exp 1/8", ok, rx_q.size() - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_q[base + i] !== exp[i]) begin failures++; $display("FAIL wrap_byte%0d got %02h exp %02h", i, rx_q[base + i], exp[i]); end
    end
    checks++;
    if (bus.SequenceNumber !== 16'h0000) begin failures++; $display("FAIL wrap_seq got %04h exp 0000", bus.SequenceNumber); end
  endtask

  task automatic test_clear();
    logic [7:0] exp [8];
    int base, s0;
    bit ok, reached;
    ram[0] = 8'h10; ram[1] = 8'h20; ram[2] = 8'h30; ram[3] = 8'h40;
    base = rx_q.size(); s0 = sent_cnt;
    start_send(16'h2222, 16'd12);
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge Clock);
      if (rx_q.size() - base >= 9) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL clear_reach_data got %0d bytes exp >=9", rx_q.size() - base); end
    #2 Clear = 1'b1;
    #1;
    checks++;
    if ({bus.TxValid, bus.Busy, bus.MessageSent, bus.ClearDataByteAddr, bus.NextDataByte} !== 5'b0) begin
      failures++; $display("FAIL clear_async got %b exp 00000", {bus.TxValid, bus.Busy, bus.MessageSent, bus.ClearDataByteAddr, bus.NextDataByte});
    end
    checks++;
    if (bus.SequenceNumber !== 16'h0000) begin failures++; $display("FAIL clear_seq got %04h exp 0000", bus.SequenceNumber); end
    @(negedge Clock);
    Clear = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if (bus.Busy !== 1'b0 || sent_cnt != s0) begin
      failures++; $display("FAIL clear_idle got busy=%b sent=%0d exp 0/0", bus.Busy, sent_cnt - s0);
    end
    exp = '{8'h34, 8'h12, 8'h08, 8'h00, 8'h33, 8'h33, 8'h00, 8'h00};
    base = rx_q.size(); s0 = sent_cnt;
    start_send(16'h3333, 16'd8);
    wait_sent(s0, ok);
    checks++;
    if (!ok || rx_q.size() - base != 8) begin failures++; $display("FAIL restart_len got ok=%0d len=%0d exp 1/8", ok, rx_q.size() - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_q[base + i] !== exp[i]) begin failures++; $display("FAIL restart_byte%0d got %02h exp %02h", i, rx_q[base + i], exp[i]); end
    end
    checks++;
    if (bus.SequenceNumber !== 16'h0001) begin failures++; $display("FAIL restart_seq got %04h exp 0001", bus.SequenceNumber); end
  endtask

  initial begin
    test_reset();
    test_header_only();
    test_payload(1'b0, 8'h01);
    test_payload(1'b1, 8'h02);
    test_clamp();
    test_busy_ignore();
    test_seq_wrap();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
